z80_bus_target: RTL



---
 rtl/z80_bus_target_pkg.sv | 32 +++
 rtl/z80_cycle_decode.sv | 42 ++++
 rtl/z80_bus_target.sv | 221 ++++++++++++++++++++++
 3 files changed

// File: rtl/z80_bus_target_pkg.sv
// Shared types and constants for the z80_bus_target bus responder.
// Holds the FSM state encoding, the decoded cycle-type codes and the timeout read value.
package z80_bus_target_pkg;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_REQ,
        ST_DRIVE,
        ST_RELEASE
    } state_t;

    typedef enum logic [2:0] {
        CYC_NONE,
        CYC_MRD,
        CYC_MWR,
        CYC_IORD,
        CYC_IOWR,
        CYC_INTA
    } cycle_t;

    // Value returned to the CPU when the backend never answers a read
    localparam logic [7:0] TIMEOUT_RDATA = 8'hFF;

    function automatic logic is_write(cycle_t c);
        return (c == CYC_MWR) || (c == CYC_IOWR);
    endfunction

    function automatic logic is_io(cycle_t c);
        return (c == CYC_IORD) || (c == CYC_IOWR);
    endfunction

endpackage

// File: rtl/z80_cycle_decode.sv
// Combinational classifier: registered Z80 strobes plus address windows -> cycle type.
// Interrupt acknowledge takes priority because it is the only cycle with nM1 and nIORQ both low.
module z80_cycle_decode
    import z80_bus_target_pkg::*;
#(
    parameter logic [15:0] MEM_BASE = 16'h8000,
    parameter logic [15:0] MEM_MASK = 16'hC000,
    parameter logic [7:0]  IO_BASE  = 8'h40,
    parameter logic [7:0]  IO_MASK  = 8'hF0
) (
    input  logic [15:0] addr,
    input  logic        n_m1,
    input  logic        n_mreq,
    input  logic        n_iorq,
    input  logic        n_rd,
    input  logic        n_wr,
    input  logic        n_rfsh,
    output cycle_t      cycle
);

    logic mem_hit;
    logic io_hit;

    assign mem_hit = (addr & MEM_MASK) == MEM_BASE;
    assign io_hit  = (addr[7:0] & IO_MASK) == IO_BASE;

    always_comb begin
        cycle = CYC_NONE;
        if (!n_m1 && !n_iorq) begin
            cycle = CYC_INTA;
        end else if (!n_mreq && !n_rd && n_rfsh && mem_hit) begin
            cycle = CYC_MRD;
        end else if (!n_mreq && !n_wr && mem_hit) begin
            cycle = CYC_MWR;
        end else if (!n_iorq && !n_rd && n_m1 && io_hit) begin
            cycle = CYC_IORD;
        end else if (!n_iorq && !n_wr && n_m1 && io_hit) begin
            cycle = CYC_IOWR;
        end
    end

endmodule

// File: rtl/z80_bus_target.sv
// Z80 bus target: turns decoded memory/IO cycles into one backend req/ack transaction,
// stretches the CPU with nWAIT meanwhile, and serves interrupt-acknowledge with a mode-2 vector.
module z80_bus_target
    import z80_bus_target_pkg::*;
#(
    parameter logic [15:0] MEM_BASE = 16'h8000,
    parameter logic [15:0] MEM_MASK = 16'hC000,
    parameter logic [7:0]  IO_BASE  = 8'h40,
    parameter logic [7:0]  IO_MASK  = 8'hF0,
    parameter int unsigned TIMEOUT  = 15
) (
    input  logic        CLK,
    input  logic        nRESET,
    input  logic [15:0] A,
    input  logic [7:0]  D_I,
    output logic [7:0]  D_O,
    output logic        D_OE,
    input  logic        nM1,
    input  logic        nMREQ,
    input  logic        nIORQ,
    input  logic        nRD,
    input  logic        nWR,
    input  logic        nRFSH,
    output logic        nWAIT,
    output logic        nINT,
    output logic        be_req,
    output logic        be_we,
    output logic        be_io,
    output logic [15:0] be_addr,
    output logic [7:0]  be_wdata,
    input  logic        be_ack,
    input  logic [7:0]  be_rdata,
    input  logic        irq,
    input  logic [7:0]  irq_vector,
    output logic        inta_stb,
    output logic        err_timeout
);

    localparam logic [7:0] TMO_LAST = 8'(TIMEOUT - 1);

    logic [15:0] a_q;
    logic        nm1_q, nmreq_q, niorq_q, nrd_q, nwr_q, nrfsh_q;
    logic        irq_q;

    state_t      state, state_d;
    cycle_t      cyc;
    logic [7:0]  tmo_cnt, tmo_cnt_d;
    logic        pending, pending_d;
    logic        drive, drive_d;
    logic        drive_iorq, drive_iorq_d;
    logic        nwait_d, nint_d, be_req_d, be_we_d, be_io_d;
    logic [15:0] be_addr_d;
    logic [7:0]  be_wdata_d, d_o_d;
    logic        inta_stb_d, err_timeout_d;
    logic        inta_clr;
    logic        done;

    always_ff @(posedge CLK or negedge nRESET) begin
        if (!nRESET) begin
            a_q     <= '0;
            nm1_q   <= 1'b1;
            nmreq_q <= 1'b1;
            niorq_q <= 1'b1;
            nrd_q   <= 1'b1;
            nwr_q   <= 1'b1;
            nrfsh_q <= 1'b1;
            irq_q   <= 1'b0;
        end else begin
            a_q     <= A;
            nm1_q   <= nM1;
            nmreq_q <= nMREQ;
            niorq_q <= nIORQ;
            nrd_q   <= nRD;
            nwr_q   <= nWR;
            nrfsh_q <= nRFSH;
            irq_q   <= irq;
        end
    end

    z80_cycle_decode #(
        .MEM_BASE (MEM_BASE),
        .MEM_MASK (MEM_MASK),
        .IO_BASE  (IO_BASE),
        .IO_MASK  (IO_MASK)
    ) u_decode (
        .addr   (a_q),
        .n_m1   (nm1_q),
        .n_mreq (nmreq_q),
        .n_iorq (niorq_q),
        .n_rd   (nrd_q),
        .n_wr   (nwr_q),
        .n_rfsh (nrfsh_q),
        .cycle  (cyc)
    );

    // Gating by the live strobe lets the data bus go tristate the instant the CPU lets go
    assign D_OE = drive && (drive_iorq ? !nIORQ : !nRD);

    always_comb begin
        state_d       = state;
        tmo_cnt_d     = tmo_cnt;
        drive_d       = drive;
        drive_iorq_d  = drive_iorq;
        nwait_d       = nWAIT;
        be_req_d      = be_req;
        be_we_d       = be_we;
        be_io_d       = be_io;
        be_addr_d     = be_addr;
        be_wdata_d    = be_wdata;
        d_o_d         = D_O;
        inta_stb_d    = 1'b0;
        err_timeout_d = 1'b0;
        inta_clr      = 1'b0;
        done          = be_ack || (tmo_cnt == TMO_LAST);

        case (state)
            ST_IDLE: begin
                if (cyc == CYC_INTA) begin
                    state_d      = ST_DRIVE;
                    d_o_d        = irq_vector;
                    inta_stb_d   = 1'b1;
                    inta_clr     = 1'b1;
                    drive_d      = 1'b1;
                    drive_iorq_d = 1'b1;
                end else if (cyc != CYC_NONE) begin
                    state_d      = ST_REQ;
                    be_req_d     = 1'b1;
                    nwait_d      = 1'b0;
                    be_addr_d    = a_q;
                    be_we_d      = is_write(cyc);
                    be_io_d      = is_io(cyc);
                    be_wdata_d   = is_write(cyc) ? D_I : be_wdata;
                    tmo_cnt_d    = '0;
                    drive_iorq_d = 1'b0;
                end
            end
            ST_REQ: begin
                if (done) begin
                    be_req_d      = 1'b0;
                    nwait_d       = 1'b1;
                    err_timeout_d = !be_ack;
                    if (be_we) begin
                        state_d = ST_RELEASE;
                    end else begin
                        d_o_d = be_ack ? be_rdata : TIMEOUT_RDATA;
                        // A read the CPU already abandoned is finished silently
                        if (!nrd_q) begin
                            state_d = ST_DRIVE;
                            drive_d = 1'b1;
                        end else begin
                            state_d = ST_IDLE;
                        end
                    end
                end else begin
                    tmo_cnt_d = tmo_cnt + 8'd1;
                end
            end
            ST_DRIVE: begin
                if (drive_iorq ? niorq_q : nrd_q) begin
                    state_d = ST_IDLE;
                    drive_d = 1'b0;
                end
            end
            ST_RELEASE: begin
                if (nmreq_q && niorq_q) begin
                    state_d = ST_IDLE;
                end
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase

        // A new irq edge outranks a simultaneous acknowledge so the request is not lost
        if (irq && !irq_q) begin
            pending_d = 1'b1;
        end else if (inta_clr) begin
            pending_d = 1'b0;
        end else begin
            pending_d = pending;
        end
        nint_d = !pending_d;
    end

    always_ff @(posedge CLK or negedge nRESET) begin
        if (!nRESET) begin
            state       <= ST_IDLE;
            tmo_cnt     <= '0;
            pending     <= 1'b0;
            drive       <= 1'b0;
            drive_iorq  <= 1'b0;
            nWAIT       <= 1'b1;
            nINT        <= 1'b1;
            be_req      <= 1'b0;
            be_we       <= 1'b0;
            be_io       <= 1'b0;
            be_addr     <= '0;
            be_wdata    <= '0;
            D_O         <= '0;
            inta_stb    <= 1'b0;
            err_timeout <= 1'b0;
        end else begin
            state       <= state_d;
            tmo_cnt     <= tmo_cnt_d;
            pending     <= pending_d;
            drive       <= drive_d;
            drive_iorq  <= drive_iorq_d;
            nWAIT       <= nwait_d;
            nINT        <= nint_d;
            be_req      <= be_req_d;
            be_we       <= be_we_d;
            be_io       <= be_io_d;
            be_addr     <= be_addr_d;
            be_wdata    <= be_wdata_d;
            D_O         <= d_o_d;
            inta_stb    <= inta_stb_d;
            err_timeout <= err_timeout_d;
        end
    end

endmodule
